led_scheduler: RTL and testbench
================================

LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the single board LED.
REQ-002 Parameter DIV, default 2097152: bit period in CLK cycles (~131 ms at 16 MHz); legal range 1..2^24.
REQ-003 CLK  input  1  16 MHz board clock, sole clock domain, all state on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester level request, held until grant.
REQ-006 pat  input  NREQ*32  per-requester blink pattern, requester i at bits [32i+31:32i].
REQ-007 reps  input  NREQ*4  per-requester extra repetitions, i at [4i+3:4i]; 0 = play once.
REQ-008 abort  input  1  terminate current playback.
REQ-009 grant  output  NREQ  one-hot, one-cycle acceptance pulse.
REQ-010 done  output  NREQ  one-hot, one-cycle completion pulse.
REQ-011 busy  output  1  high while a pattern is playing.
REQ-012 LED  output  1  drives the user LED.

Function
REQ-013 FSM states SHALL be IDLE and PLAY only.
REQ-014 IDLE: LED=0, busy=0, prescaler and bit index held at 0.
REQ-015 IDLE with any req high at edge k: winner selected round-robin, search starting at index (last_grant+1) mod NREQ; at edge k, pat/reps of the winner are captured, grant[winner]=1 for exactly the cycle after edge k, state->PLAY.
REQ-016 Round-robin pointer last_grant SHALL update to winner on each grant; reset value NREQ-1 so index 0 wins first.
REQ-017 PLAY: LED = captured_pat[bit_idx], bit_idx starts at 0 (LSB first), busy=1.
REQ-018 Prescaler counts 0..DIV-1 in PLAY; tick when count==DIV-1, count then wraps to 0; DIV=1 ticks every cycle.
REQ-019 On tick with bit_idx<31: bit_idx increments.
REQ-020 On tick with bit_idx==31 and rep_cnt>0: rep_cnt decrements, bit_idx wraps to 0, playback continues without gap.
REQ-021 On tick with bit_idx==31 and rep_cnt==0: done[owner]=1 the following cycle, state->IDLE, LED=0.
REQ-022 Total playback = 32*DIV*(reps+1) cycles from first PLAY cycle to done pulse.
REQ-023 Changes to req/pat/reps during PLAY SHALL NOT affect current playback; captured values are authoritative.
REQ-024 abort in PLAY: state->IDLE next edge, LED=0, no done pulse; abort in IDLE ignored.
REQ-025 abort and final tick same cycle: abort wins, no done.
REQ-026 A requester whose done pulses and whose req is still high is re-eligible on the next IDLE cycle under round-robin; no new arbitration occurs in the done cycle itself (one IDLE cycle minimum between playbacks).
REQ-027 Pattern 32'h0 SHALL play full duration with LED dark.

Reset
REQ-028 RST high at an edge: state=IDLE, LED=0, busy=0, grant=0, done=0, prescaler=0, bit_idx=0, rep_cnt=0, last_grant=NREQ-1.
REQ-029 RST mid-PLAY aborts playback with no done; RST dominates abort, req and tick.

Structure
REQ-030 Shared package led_pkg SHALL hold PAT_W=32, REP_W=4, BIDX_W=5 and the IDLE/PLAY state encoding.
REQ-031 Arbitration SHALL live in sub-module rr_arbiter (req vector + pointer in, one-hot winner + valid out, purely combinational); all sequencing stays in led_scheduler.

Verification (DIV=4, NREQ=3)
REQ-032 req=3'b001, pat0=32'h0000_0005, reps0=0 -> grant=001 one cycle; LED 1 for 4 cycles, 0 for 4, 1 for 4, then 0; done=001 exactly 128 cycles after first PLAY cycle.
REQ-033 req=3'b111 held continuously, reps=0 -> grant order 001,010,100,001; one IDLE cycle between each done and the next grant.
REQ-034 pat1=32'h8000_0001, reps1=2 -> LED high in bit 0 and bit 31 of each of 3 passes, no gap at wrap; done after 384 cycles.
REQ-035 abort asserted at cycle 50 of playback -> IDLE next edge, LED=0, busy=0, no done pulse; abort coincident with final tick -> no done.
REQ-036 RST asserted mid-PLAY -> all outputs 0 next cycle; with req=3'b110 afterwards, first grant=010 (pointer reset).

Source files
------------

// File: rtl/led_pkg.sv
// Shared widths and FSM encoding for the LED blink scheduler.
package led_pkg;

  localparam int unsigned PAT_W  = 32;
  localparam int unsigned REP_W  = 4;
  localparam int unsigned BIDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  int unsigned       idx;
  logic [IDX_W-1:0]  sel;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + 32'd1 + i) % N;
      sel = idx[IDX_W-1:0];
      if (!valid && req[sel]) begin
        gnt[sel] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Shares one board LED among NREQ requesters; each grant plays a captured
// 32-bit pattern LSB first, one bit per DIV cycles, repeated reps+1 times.
module led_scheduler
  import led_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DIV  = 2097152
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*PAT_W-1:0] pat,
  input  logic [NREQ*REP_W-1:0] reps,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  LED
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [BIDX_W-1:0] BIDX_MAX = '1;
  localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NREQ - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     done_q, done_d;

  logic [NREQ-1:0]     arb_gnt;
  logic                arb_valid;
  logic                tick;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (last_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    rep_d   = rep_q;
    pat_d   = pat_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bidx_d = '0;
        // The done cycle is a forced idle gap: no arbitration while done pulses.
        if (arb_valid && (done_q == '0)) begin
          state_d = PLAY;
          grant_d = arb_gnt;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
              pat_d   = pat[i*PAT_W +: PAT_W];
              rep_d   = reps[i*REP_W +: REP_W];
              owner_d = IDX_W'(i);
              last_d  = IDX_W'(i);
            end
          end
        end
      end
      PLAY: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          bidx_d  = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (bidx_q != BIDX_MAX) begin
            bidx_d = bidx_q + 1'b1;
          end else if (rep_q != '0) begin
            rep_d  = rep_q - 1'b1;
            bidx_d = '0;
          end else begin
            state_d = IDLE;
            bidx_d  = '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
              done_d[i] = (owner_q == IDX_W'(i));
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      rep_q   <= '0;
      pat_q   <= '0;
      owner_q <= '0;
      last_q  <= PTR_RST;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q == PLAY);
  assign LED   = (state_q == PLAY) & pat_q[bidx_q];

endmodule

// File: tb/tb_led_scheduler.sv
// Directed bench for led_scheduler with DIV=4, NREQ=3; outputs sampled on negedge.
module tb_led_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  req;
  logic [95:0] pat;
  logic [11:0] reps;
  logic        abort;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        LED;

  int total = 0;
  int bad   = 0;

  led_scheduler #(
    .NREQ (3),
    .DIV  (4)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .req   (req),
    .pat   (pat),
    .reps  (reps),
    .abort (abort),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .LED   (LED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic do_reset();
    RST   = 1'b1;
    req   = 3'b000;
    abort = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    req   = 3'b111;
    abort = 1'b1;
    pat   = {3{32'hFFFF_FFFF}};
    reps  = '0;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0 || LED !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b done=%b busy=%b led=%b want all 0",
               grant, done, busy, LED);
    end
    RST   = 1'b0;
    abort = 1'b0;
    @(negedge CLK);
    total++;
    if (grant !== 3'b001) begin
      bad++;
      $display("FAIL reset_pointer got grant=%b want=001", grant);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic exp;
    do_reset();
    pat[31:0] = 32'h0000_0005;
    reps[3:0] = 4'd0;
    req       = 3'b001;
    @(negedge CLK);
    total++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant got grant=%b busy=%b want grant=001 busy=1", grant, busy);
    end
    req = 3'b000;
    for (int p = 0; p < 128; p++) begin
      exp = (p < 4) || (p >= 8 && p < 12);
      total++;
      if (LED !== exp || busy !== 1'b1 || done !== 3'b000) begin
        bad++;
        $display("FAIL single_led cycle=%0d got led=%b busy=%b done=%b want led=%b busy=1 done=000",
                 p, LED, busy, done, exp);
      end
      if (p == 1) begin
        total++;
        if (grant !== 3'b000) begin
          bad++;
          $display("FAIL single_grant_pulse got grant=%b want=000", grant);
        end
      end
      @(negedge CLK);
    end
    total++;
    if (done !== 3'b001 || busy !== 1'b0 || LED !== 1'b0) begin
      bad++;
      $display("FAIL single_done got done=%b busy=%b led=%b want done=001 busy=0 led=0",
               done, busy, LED);
    end
    @(negedge CLK);
    total++;
    if (done !== 3'b000) begin
      bad++;
      $display("FAIL single_done_pulse got done=%b want=000", done);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [4];
    int n;
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    pat  = {32'h1, 32'h1, 32'h1};
    reps = '0;
    req  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        @(negedge CLK);
        total++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
          bad++;
          $display("FAIL rr_gap k=%0d got grant=%b busy=%b want grant=000 busy=0", k, grant, busy);
        end
      end
      @(negedge CLK);
      total++;
      if (grant !== order[k]) begin
        bad++;
        $display("FAIL rr_grant k=%0d got=%b want=%b", k, grant, order[k]);
      end
      n = 0;
      while (done === 3'b000 && n < 200) begin
        @(negedge CLK);
        n++;
      end
      total++;
      if (n != 128 || done !== order[k]) begin
        bad++;
        $display("FAIL rr_done k=%0d got cycles=%0d done=%b want cycles=128 done=%b",
                 k, n, done, order[k]);
      end
    end
    req = 3'b000;
    @(negedge CLK);
  endtask

  task automatic test_reps();
    logic exp;
    int   b;
    do_reset();
    pat[63:32] = 32'h8000_0001;
    reps[7:4]  = 4'd2;
    req        = 3'b010;
    @(negedge CLK);
    total++;
    if (grant !== 3'b010) begin
      bad++;
      $display("FAIL reps_grant got=%b want=010", grant);
    end
    // Captured values must ignore these changes.
    req        = 3'b000;
    pat[63:32] = 32'h0000_0000;
    reps[7:4]  = 4'hF;
    for (int p = 0; p < 384; p++) begin
      b   = (p % 128) / 4;
      exp = (b == 0) || (b == 31);
      total++;
      if (LED !== exp || busy !== 1'b1 || done !== 3'b000) begin
        bad++;
        $display("FAIL reps_led cycle=%0d got led=%b busy=%b done=%b want led=%b busy=1 done=000",
                 p, LED, busy, done, exp);
      end
      @(negedge CLK);
    end
    total++;
    if (done !== 3'b010 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reps_done got done=%b busy=%b want done=010 busy=0", done, busy);
    end
  endtask

  task automatic test_abort();
    int ndone;
    do_reset();
    pat[31:0] = 32'hFFFF_FFFF;
    reps[3:0] = 4'd0;
    req       = 3'b001;
    @(negedge CLK);
    total++;
    if (grant !== 3'b001) begin
      bad++;
      $display("FAIL abort_grant got=%b want=001", grant);
    end
    req = 3'b000;
    repeat (50) @(negedge CLK);
    total++;
    if (LED !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got led=%b busy=%b want led=1 busy=1", LED, busy);
    end
    abort = 1'b1;
    @(negedge CLK);
    total++;
    if (busy !== 1'b0 || LED !== 1'b0 || done !== 3'b000) begin
      bad++;
      $display("FAIL abort_stop got busy=%b led=%b done=%b want busy=0 led=0 done=000",
               busy, LED, done);
    end
    abort = 1'b0;
    ndone = 0;
    repeat (150) begin
      @(negedge CLK);
      if (done !== 3'b000) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL abort_no_done got pulses=%0d want=0", ndone);
    end
    // Abort while idle must not block arbitration.
    abort = 1'b1;
    req   = 3'b001;
    @(negedge CLK);
    total++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle got grant=%b busy=%b want grant=001 busy=1", grant, busy);
    end
    abort = 1'b0;
    req   = 3'b000;
    repeat (127) @(negedge CLK);
    total++;
    if (busy !== 1'b1 || LED !== 1'b1) begin
      bad++;
      $display("FAIL abort_last_bit got busy=%b led=%b want busy=1 led=1", busy, LED);
    end
    abort = 1'b1;
    @(negedge CLK);
    total++;
    if (done !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_final_tick got done=%b busy=%b want done=000 busy=0", done, busy);
    end
    abort = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge CLK);
      if (done !== 3'b000) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL abort_final_no_done got pulses=%0d want=0", ndone);
    end
  endtask

  task automatic test_rst_mid_play();
    int n;
    do_reset();
    pat[31:0] = 32'hFFFF_FFFF;
    pat[63:32] = 32'h0000_0001;
    reps       = '0;
    req        = 3'b001;
    @(negedge CLK);
    req = 3'b000;
    repeat (20) @(negedge CLK);
    total++;
    if (busy !== 1'b1 || LED !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got busy=%b led=%b want busy=1 led=1", busy, LED);
    end
    RST   = 1'b1;
    abort = 1'b1;
    req   = 3'b111;
    @(negedge CLK);
    total++;
    if (grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0 || LED !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got grant=%b done=%b busy=%b led=%b want all 0",
               grant, done, busy, LED);
    end
    RST   = 1'b0;
    abort = 1'b0;
    req   = 3'b110;
    @(negedge CLK);
    total++;
    if (grant !== 3'b010) begin
      bad++;
      $display("FAIL rst_regrant got=%b want=010", grant);
    end
    req = 3'b000;
    n   = 0;
    while (done === 3'b000 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (n != 128 || done !== 3'b010) begin
      bad++;
      $display("FAIL rst_first_done got cycles=%0d done=%b want cycles=128 done=010", n, done);
    end
  endtask

  task automatic test_zero_pattern();
    int nbad;
    do_reset();
    pat[95:64] = 32'h0000_0000;
    reps[11:8] = 4'd0;
    req        = 3'b100;
    @(negedge CLK);
    total++;
    if (grant !== 3'b100) begin
      bad++;
      $display("FAIL zero_grant got=%b want=100", grant);
    end
    req  = 3'b000;
    nbad = 0;
    for (int p = 0; p < 128; p++) begin
      if (LED !== 1'b0 || busy !== 1'b1 || done !== 3'b000) nbad++;
      @(negedge CLK);
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL zero_dark got bad_cycles=%0d want=0", nbad);
    end
    total++;
    if (done !== 3'b100 || LED !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got done=%b led=%b want done=100 led=0", done, LED);
    end
  endtask

  initial begin
    RST   = 1'b1;
    req   = 3'b000;
    abort = 1'b0;
    pat   = '0;
    reps  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_reps();
    test_abort();
    test_rst_mid_play();
    test_zero_pattern();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
